// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit framer.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam int          PREAMBLE_LEN  = 7;

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected IEEE 802.3 CRC-32, purely combinational.
module crc32_d8
  import gmii_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Eight LSB-first shifts of the reflected LFSR with the byte folded in up front.
  always_comb begin
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, zero padding, FCS append, inter-frame gap.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line idle, waiting for in_valid (nothing consumed here)
// PRE     | 7 preamble bytes of 0x55
// SFD     | start-of-frame delimiter 0xD5, CRC register reloaded
// DATA    | pass-through of upstream bytes, in_ready high
// PAD     | 0x00 bytes until the minimum frame length is reached
// FCS     | four bytes of ~crc, least-significant byte first
// IFG     | idle gap; in_valid ignored until it expires
module gmii_tx_framer
  import gmii_tx_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_BYTES     = 12
) (
  input  logic       clk125MHz,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  // The IDLE cycle that follows IFG is also an idle byte on the wire, so the
  // IFG state itself lasts one cycle less than the configured gap.
  localparam logic [7:0] IFG_LOAD = (IFG_BYTES > 2) ? 8'(IFG_BYTES - 2) : 8'd0;
  localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] FCS_LOAD = 8'd3;

  state_t      state;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;
  logic [7:0]  crc_data;
  logic [7:0]  fcs_byte;
  logic [7:0]  tmr;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic        pad_needed;
  logic        done_pend;

  assign in_ready     = (state == ST_DATA);
  assign busy         = (state != ST_IDLE);
  assign crc_data     = (state == ST_PAD) ? 8'h00 : in_data;
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign pad_needed   = $signed({21'd0, byte_cnt_inc}) < MIN_FRAME_LEN;
  assign fcs_word     = ~crc;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_data),
    .crc_out (crc_next)
  );

  // FCS byte select: the down-counter runs 3..0, so byte 0 goes out first.
  always_comb begin
    fcs_byte = fcs_word[7:0];
    case (tmr[1:0])
      2'd3:    fcs_byte = fcs_word[7:0];
      2'd2:    fcs_byte = fcs_word[15:8];
      2'd1:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  // Framing FSM with registered GMII outputs and status pulses.
  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state      <= ST_IDLE;
      crc        <= CRC32_INIT;
      tmr        <= 8'd0;
      byte_cnt   <= 11'd0;
      done_pend  <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (in_valid) begin
            state <= ST_PRE;
            tmr   <= PRE_LOAD;
          end
        end
        ST_PRE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= PREAMBLE_BYTE;
          if (tmr == 8'd0) state <= ST_SFD;
          else             tmr   <= tmr - 8'd1;
        end
        ST_SFD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= SFD_BYTE;
          crc        <= CRC32_INIT;
          byte_cnt   <= 11'd0;
          state      <= ST_DATA;
        end
        ST_DATA: begin
          gmii_tx_en <= 1'b1;
          if (in_valid) begin
            gmii_txd <= in_data;
            crc      <= crc_next;
            byte_cnt <= byte_cnt_inc;
            if (in_last) begin
              if (pad_needed) begin
                state <= ST_PAD;
              end else begin
                state <= ST_FCS;
                tmr   <= FCS_LOAD;
              end
            end
          end else begin
            // Starved mid-frame: poison the frame on the wire and skip the FCS.
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b1;
            underrun   <= 1'b1;
            state      <= ST_IFG;
            tmr        <= IFG_LOAD;
          end
        end
        ST_PAD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h00;
          crc        <= crc_next;
          byte_cnt   <= byte_cnt_inc;
          if (!pad_needed) begin
            state <= ST_FCS;
            tmr   <= FCS_LOAD;
          end
        end
        ST_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_byte;
          if (tmr == 8'd0) begin
            state     <= ST_IFG;
            tmr       <= IFG_LOAD;
            done_pend <= 1'b1;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        ST_IFG: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          frame_done <= done_pend;
          done_pend  <= 1'b0;
          if (tmr == 8'd0) state <= ST_IDLE;
          else             tmr   <= tmr - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: one instance with padding disabled, one with defaults.
module tb_gmii_tx_framer;

  logic clk125MHz = 1'b0;
  always #4 clk125MHz = ~clk125MHz;

  logic rst = 1'b1;

  // Instance A: MIN_FRAME_LEN = 0
  logic [7:0] a_in_data = 8'h00;
  logic       a_in_valid = 1'b0, a_in_last = 1'b0, a_in_ready;
  logic [7:0] a_txd;
  logic       a_en, a_er, a_busy, a_done, a_under;

  // Instance B: default parameters
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [7:0] txd;
  logic       en, er, busy, done, under;

  gmii_tx_framer #(.MIN_FRAME_LEN(0)) dut_a (
    .clk125MHz (clk125MHz), .rst (rst),
    .in_data (a_in_data), .in_valid (a_in_valid), .in_last (a_in_last), .in_ready (a_in_ready),
    .gmii_txd (a_txd), .gmii_tx_en (a_en), .gmii_tx_er (a_er),
    .busy (a_busy), .frame_done (a_done), .underrun (a_under)
  );

  gmii_tx_framer dut_b (
    .clk125MHz (clk125MHz), .rst (rst),
    .in_data (in_data), .in_valid (in_valid), .in_last (in_last), .in_ready (in_ready),
    .gmii_txd (txd), .gmii_tx_en (en), .gmii_tx_er (er),
    .busy (busy), .frame_done (done), .underrun (under)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] fb [0:2047];
  logic [7:0] exp_q [$];

  // Wire monitors, sampled on the falling edge.
  logic [7:0] wq_a [$];
  logic [7:0] wq_b [$];
  int cyc = 0;
  int done_a = 0;
  int en_runs_b = 0, done_b = 0, under_b = 0, er_b = 0, er_bad_b = 0;
  int fd_bad_b = 0, rdy_viol_b = 0, gap_b = 0, last_hi_b = 0;
  logic prev_en_b = 1'b0;

  always @(negedge clk125MHz) begin
    cyc = cyc + 1;
    if (a_en === 1'b1) wq_a.push_back(a_txd);
    if (a_done === 1'b1) done_a = done_a + 1;
    if (en === 1'b1) begin
      wq_b.push_back(txd);
      if (!prev_en_b) begin
        en_runs_b = en_runs_b + 1;
        gap_b = cyc - last_hi_b - 1;
      end
      last_hi_b = cyc;
    end
    if (done === 1'b1) begin
      done_b = done_b + 1;
      if (!prev_en_b || en !== 1'b0) fd_bad_b = fd_bad_b + 1;
    end
    if (under === 1'b1) under_b = under_b + 1;
    if (er === 1'b1) begin
      er_b = er_b + 1;
      if (txd !== 8'h00 || under !== 1'b1 || en !== 1'b1) er_bad_b = er_bad_b + 1;
    end
    if (in_ready === 1'b1 && en !== 1'b1) rdy_viol_b = rdy_viol_b + 1;
    prev_en_b = (en === 1'b1);
  end

  task automatic clear_mon();
    wq_a.delete(); wq_b.delete();
    done_a = 0; en_runs_b = 0; done_b = 0; under_b = 0; er_b = 0; er_bad_b = 0;
    fd_bad_b = 0; rdy_viol_b = 0; gap_b = 0;
  endtask

  // Independent bitwise CRC-32 (reflected), returns the FCS value.
  function automatic logic [31:0] sw_fcs(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Appends the expected on-wire bytes of a frame held in fb (pad area must be zeroed).
  function automatic void build_exp(input int len, input int minlen);
    int l = (len > minlen) ? len : minlen;
    logic [31:0] f;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < l; i++) exp_q.push_back(fb[i]);
    f = sw_fcs(l);
    exp_q.push_back(f[7:0]); exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]); exp_q.push_back(f[31:24]);
  endfunction

  // Presents fb[0..stop_at-1] upstream; leaves in_valid as last driven.
  task automatic drive(input bit use_a, input int len, input int stop_at);
    int idx = 0;
    int guard = 0;
    while (idx < stop_at && guard < 4000) begin
      @(negedge clk125MHz);
      guard++;
      if (use_a) begin
        a_in_valid = 1'b1; a_in_data = fb[idx]; a_in_last = (idx == len - 1);
        if (a_in_ready === 1'b1) idx++;
      end else begin
        in_valid = 1'b1; in_data = fb[idx]; in_last = (idx == len - 1);
        if (in_ready === 1'b1) idx++;
      end
    end
    tests++;
    if (idx != stop_at) begin
      fails++;
      $display("FAIL drive_accept: accepted %0d bytes, required %0d", idx, stop_at);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk125MHz);
    #1;
    tests++;
    if ({txd, en, er, busy, done, under, in_ready} !== 15'd0) begin
      fails++;
      $display("FAIL reset_b: got %h, required 0", {txd, en, er, busy, done, under, in_ready});
    end
    tests++;
    if ({a_txd, a_en, a_er, a_busy, a_done, a_under, a_in_ready} !== 15'd0) begin
      fails++;
      $display("FAIL reset_a: got %h, required 0", {a_txd, a_en, a_er, a_busy, a_done, a_under, a_in_ready});
    end
    rst = 1'b0;
    @(negedge clk125MHz); #1;
    clear_mon();
  endtask

  task automatic test_check_vector();
    logic [7:0] ref_b [0:20] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                                 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                 8'h26, 8'h39, 8'hF4, 8'hCB};
    int bad = -1;
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    clear_mon();
    drive(1'b1, 9, 9);
    @(negedge clk125MHz); a_in_valid = 1'b0; a_in_last = 1'b0;
    for (int g = 0; g < 200 && done_a == 0; g++) @(negedge clk125MHz);
    repeat (4) @(negedge clk125MHz);
    #1;
    tests++;
    if (wq_a.size() != 21) begin
      fails++; $display("FAIL vec_len: got %0d bytes, required 21", wq_a.size());
    end
    for (int i = 0; i < 21 && i < wq_a.size(); i++) if (bad < 0 && wq_a[i] !== ref_b[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++; $display("FAIL vec_byte[%0d]: got %h, required %h", bad, wq_a[bad], ref_b[bad]);
    end
    tests++;
    if (done_a != 1) begin
      fails++; $display("FAIL vec_done: got %0d pulses, required 1", done_a);
    end
  endtask

  task automatic test_pad();
    int bad = -1;
    for (int i = 0; i < 64; i++) fb[i] = (i < 14) ? 8'(i * 13 + 5) : 8'h00;
    exp_q.delete(); build_exp(14, 60);
    clear_mon();
    drive(1'b0, 14, 14);
    @(negedge clk125MHz); in_valid = 1'b0; in_last = 1'b0;
    for (int g = 0; g < 300 && done_b == 0; g++) @(negedge clk125MHz);
    repeat (4) @(negedge clk125MHz);
    #1;
    tests++;
    if (wq_b.size() != 72) begin
      fails++; $display("FAIL pad_len: got %0d tx_en cycles, required 72", wq_b.size());
    end
    tests++;
    if (en_runs_b != 1) begin
      fails++; $display("FAIL pad_contig: got %0d tx_en bursts, required 1", en_runs_b);
    end
    for (int i = 0; i < exp_q.size() && i < wq_b.size(); i++) if (bad < 0 && wq_b[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++; $display("FAIL pad_byte[%0d]: got %h, required %h", bad, wq_b[bad], exp_q[bad]);
    end
    tests++;
    if (done_b != 1 || fd_bad_b != 0) begin
      fails++; $display("FAIL pad_done: got %0d pulses (%0d misplaced), required 1 (0)", done_b, fd_bad_b);
    end
  endtask

  task automatic test_back_to_back();
    int bad = -1;
    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    exp_q.delete(); build_exp(64, 60);
    clear_mon();
    drive(1'b0, 64, 64);
    for (int i = 0; i < 64; i++) fb[i] = 8'(255 - i);
    build_exp(64, 60);
    drive(1'b0, 64, 64);
    @(negedge clk125MHz); in_valid = 1'b0; in_last = 1'b0;
    for (int g = 0; g < 600 && done_b < 2; g++) @(negedge clk125MHz);
    repeat (4) @(negedge clk125MHz);
    #1;
    tests++;
    if (wq_b.size() != 152 || en_runs_b != 2) begin
      fails++; $display("FAIL b2b_len: got %0d bytes in %0d bursts, required 152 in 2", wq_b.size(), en_runs_b);
    end
    for (int i = 0; i < exp_q.size() && i < wq_b.size(); i++) if (bad < 0 && wq_b[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++; $display("FAIL b2b_byte[%0d]: got %h, required %h", bad, wq_b[bad], exp_q[bad]);
    end
    tests++;
    if (gap_b != 12) begin
      fails++; $display("FAIL b2b_gap: got %0d idle cycles, required 12", gap_b);
    end
    tests++;
    if (rdy_viol_b != 0) begin
      fails++; $display("FAIL b2b_ready_in_gap: got %0d cycles with in_ready high, required 0", rdy_viol_b);
    end
    tests++;
    if (done_b != 2 || fd_bad_b != 0) begin
      fails++; $display("FAIL b2b_done: got %0d pulses (%0d misplaced), required 2 (0)", done_b, fd_bad_b);
    end
  endtask

  task automatic test_underrun();
    int bad = -1;
    for (int i = 0; i < 64; i++) fb[i] = 8'(i + 100);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 20; i++) exp_q.push_back(fb[i]);
    exp_q.push_back(8'h00);
    clear_mon();
    drive(1'b0, 64, 20);
    @(negedge clk125MHz); in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 64; i++) fb[i] = (i < 10) ? 8'(i * 3 + 1) : 8'h00;
    drive(1'b0, 10, 10);
    @(negedge clk125MHz); in_valid = 1'b0; in_last = 1'b0;
    for (int g = 0; g < 300 && done_b == 0; g++) @(negedge clk125MHz);
    repeat (4) @(negedge clk125MHz);
    #1;
    tests++;
    if (under_b != 1 || er_b != 1 || er_bad_b != 0) begin
      fails++; $display("FAIL underrun_flags: got under=%0d er=%0d bad=%0d, required 1 1 0", under_b, er_b, er_bad_b);
    end
    for (int i = 0; i < 29 && i < wq_b.size(); i++) if (bad < 0 && wq_b[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0 || wq_b.size() < 29) begin
      fails++; $display("FAIL underrun_byte[%0d]: got %0d bytes, required 29 matching prefix", bad, wq_b.size());
    end
    tests++;
    if (gap_b != 12) begin
      fails++; $display("FAIL underrun_gap: got %0d idle cycles, required 12", gap_b);
    end
    tests++;
    if (done_b != 1 || en_runs_b != 2) begin
      fails++; $display("FAIL underrun_done: got %0d pulses %0d bursts, required 1 2", done_b, en_runs_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad = -1;
    for (int i = 0; i < 64; i++) fb[i] = 8'(i) ^ 8'h5A;
    clear_mon();
    drive(1'b0, 64, 64);
    @(negedge clk125MHz); in_valid = 1'b0; in_last = 1'b0;
    #1;
    for (int g = 0; g < 200 && wq_b.size() < 75; g++) begin
      @(negedge clk125MHz); #1;
    end
    rst = 1'b1;
    @(negedge clk125MHz); #1;
    tests++;
    if ({txd, en, er, busy, done, under, in_ready} !== 15'd0 || wq_b.size() != 75) begin
      fails++;
      $display("FAIL midrst_outputs: got %h after %0d bytes, required 0 after 75",
               {txd, en, er, busy, done, under, in_ready}, wq_b.size());
    end
    rst = 1'b0;
    for (int i = 0; i < 64; i++) fb[i] = (i < 30) ? 8'(i * 7) : 8'h00;
    exp_q.delete(); build_exp(30, 60);
    @(negedge clk125MHz); #1;
    clear_mon();
    drive(1'b0, 30, 30);
    @(negedge clk125MHz); in_valid = 1'b0; in_last = 1'b0;
    for (int g = 0; g < 300 && done_b == 0; g++) @(negedge clk125MHz);
    repeat (4) @(negedge clk125MHz);
    #1;
    for (int i = 0; i < exp_q.size() && i < wq_b.size(); i++) if (bad < 0 && wq_b[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0 || wq_b.size() != 72 || done_b != 1) begin
      fails++;
      $display("FAIL midrst_next_frame: got %0d bytes, first bad %0d, done %0d; required 72, none, 1", wq_b.size(), bad, done_b);
    end
  endtask

  task automatic test_long();
    int bad = -1;
    for (int i = 0; i < 1514; i++) fb[i] = 8'(i * 31 + 7);
    exp_q.delete(); build_exp(1514, 60);
    clear_mon();
    drive(1'b0, 1514, 1514);
    @(negedge clk125MHz); in_valid = 1'b0; in_last = 1'b0;
    for (int g = 0; g < 300 && done_b == 0; g++) @(negedge clk125MHz);
    repeat (4) @(negedge clk125MHz);
    #1;
    tests++;
    if (wq_b.size() != 1526 || en_runs_b != 1) begin
      fails++; $display("FAIL long_len: got %0d cycles in %0d bursts, required 1526 in 1", wq_b.size(), en_runs_b);
    end
    for (int i = 0; i < exp_q.size() && i < wq_b.size(); i++) if (bad < 0 && wq_b[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++; $display("FAIL long_byte[%0d]: got %h, required %h", bad, wq_b[bad], exp_q[bad]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_check_vector();
    test_pad();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_long();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
